// File: rtl/mux_nto1_pipe.sv
// N-to-1 operand select feeding a DEPTH-stage valid/ready register pipeline.
// Supports a sticky select lock and flags out-of-range selects with the beat.
module mux_nto1_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 3,
    parameter int DEPTH  = 2,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    lock_en,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    // With a power-of-two channel count every select value is a real channel.
    localparam bit               SEL_POW2 = ((NUM_IN & (NUM_IN - 1)) == 0);
    localparam logic [SEL_W:0]   NUM_IN_C = (SEL_W + 1)'(NUM_IN);

    logic [SEL_W-1:0] lock_sel_r;
    logic [SEL_W-1:0] eff_sel_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_bad_s;
    logic             accept_s;
    logic             sel_err_r;
    logic             chain_s;

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] err_r;
    logic [WIDTH-1:0] dat_r [DEPTH];
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] src_vld_s;
    logic [DEPTH-1:0] src_err_s;
    logic [WIDTH-1:0] src_dat_s [DEPTH];

    // Effective select, range check and channel mux for the offered beat.
    always_comb begin
        eff_sel_s  = lock_en ? lock_sel_r : in_sel;
        sel_bad_s  = 1'b0;
        sel_data_s = '0;
        if (!SEL_POW2) begin
            sel_bad_s = ({1'b0, eff_sel_s} >= NUM_IN_C);
        end else begin
            sel_bad_s = 1'b0;
        end
        // No channel matches an out-of-range select, so its data stays zero.
        for (int i = 0; i < NUM_IN; i++) begin
            if (eff_sel_s == SEL_W'(i)) begin
                sel_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Ready chain from the tail back to stage 0: a stage loads when empty or draining.
    always_comb begin
        chain_s = out_ready;
        load_s  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            load_s[k] = !vld_r[k] | chain_s;
            chain_s   = load_s[k];
        end
    end

    assign in_ready = rst_n & load_s[0];
    assign accept_s = in_valid & in_ready;

    // Source of each stage: the mux for stage 0, the previous stage otherwise.
    always_comb begin
        src_vld_s    = '0;
        src_err_s    = '0;
        src_vld_s[0] = in_valid;
        src_err_s[0] = sel_bad_s;
        src_dat_s[0] = sel_data_s;
        for (int k = 1; k < DEPTH; k++) begin
            src_vld_s[k] = vld_r[k-1];
            src_err_s[k] = err_r[k-1];
            src_dat_s[k] = dat_r[k-1];
        end
    end

    // Pipeline stage registers; payload only moves with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            err_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load_s[k]) begin
                    vld_r[k] <= src_vld_s[k];
                    if (src_vld_s[k]) begin
                        dat_r[k] <= src_dat_s[k];
                        err_r[k] <= src_err_s[k];
                    end
                end
            end
        end
    end

    // Select lock capture and sticky range-error flag (a new error beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sel_r <= '0;
            sel_err_r  <= 1'b0;
        end else begin
            if (accept_s && !lock_en) begin
                lock_sel_r <= in_sel;
            end
            if (accept_s && sel_bad_s) begin
                sel_err_r <= 1'b1;
            end else if (err_clr) begin
                sel_err_r <= 1'b0;
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];
    assign out_err   = SEL_POW2 ? 1'b0 : err_r[DEPTH-1];
    assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: three configurations share one random
// stimulus stream and are compared every cycle against a beat-queue reference model.
module tb_mux_nto1_pipe;

    localparam int WA = 16, NA = 3, DA = 2, SA = $clog2(NA);
    localparam int WB = 8,  NB = 4, DB = 1, SB = $clog2(NB);
    localparam int WC = 32, NC = 5, DC = 4, SC = $clog2(NC);
    localparam int PW [3] = '{WA, WB, WC};
    localparam int PN [3] = '{NA, NB, NC};
    localparam int PD [3] = '{DA, DB, DC};
    localparam int PS [3] = '{SA, SB, SC};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, lock_en, err_clr, out_ready;
    logic [3:0]  sel_raw;
    logic [31:0] ch [5];

    always #5 clk = ~clk;

    logic [NA*WA-1:0] in_data_a;
    logic [NB*WB-1:0] in_data_b;
    logic [NC*WC-1:0] in_data_c;
    logic [WA-1:0]    out_data_a;
    logic [WB-1:0]    out_data_b;
    logic [WC-1:0]    out_data_c;
    logic in_ready_a, out_err_a, out_valid_a, sel_err_a;
    logic in_ready_b, out_err_b, out_valid_b, sel_err_b;
    logic in_ready_c, out_err_c, out_valid_c, sel_err_c;

    always_comb for (int i = 0; i < NA; i++) in_data_a[i*WA +: WA] = ch[i][WA-1:0];
    always_comb for (int i = 0; i < NB; i++) in_data_b[i*WB +: WB] = ch[i][WB-1:0];
    always_comb for (int i = 0; i < NC; i++) in_data_c[i*WC +: WC] = ch[i][WC-1:0];

    mux_nto1_pipe #(.WIDTH(WA), .NUM_IN(NA), .DEPTH(DA)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_sel(sel_raw[SA-1:0]),
        .in_valid(in_valid), .in_ready(in_ready_a), .lock_en(lock_en),
        .out_data(out_data_a), .out_err(out_err_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .sel_err(sel_err_a), .err_clr(err_clr));

    mux_nto1_pipe #(.WIDTH(WB), .NUM_IN(NB), .DEPTH(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_sel(sel_raw[SB-1:0]),
        .in_valid(in_valid), .in_ready(in_ready_b), .lock_en(lock_en),
        .out_data(out_data_b), .out_err(out_err_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .sel_err(sel_err_b), .err_clr(err_clr));

    mux_nto1_pipe #(.WIDTH(WC), .NUM_IN(NC), .DEPTH(DC)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_sel(sel_raw[SC-1:0]),
        .in_valid(in_valid), .in_ready(in_ready_c), .lock_en(lock_en),
        .out_data(out_data_c), .out_err(out_err_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .sel_err(sel_err_c), .err_clr(err_clr));

    logic        o_rdy [3], o_vld [3], o_err [3], o_serr [3];
    logic [31:0] o_dat [3];
    assign o_rdy[0] = in_ready_a;  assign o_rdy[1] = in_ready_b;  assign o_rdy[2] = in_ready_c;
    assign o_vld[0] = out_valid_a; assign o_vld[1] = out_valid_b; assign o_vld[2] = out_valid_c;
    assign o_err[0] = out_err_a;   assign o_err[1] = out_err_b;   assign o_err[2] = out_err_c;
    assign o_serr[0] = sel_err_a;  assign o_serr[1] = sel_err_b;  assign o_serr[2] = sel_err_c;
    assign o_dat[0] = {16'd0, out_data_a};
    assign o_dat[1] = {24'd0, out_data_b};
    assign o_dat[2] = out_data_c;

    // Reference model: per configuration, an ordered list of in-flight beats with
    // the stage each currently occupies (DEPTH-1 is the output).
    int          cnt [3];
    logic [31:0] qd  [3][4];
    bit          qe  [3][4];
    int          qp  [3][4];
    int          lsel [3];
    bit          serr [3];

    bit          s_rdy [3], s_vld [3], s_err [3], s_serr [3], p_acc [3];
    logic [31:0] s_dat [3];
    logic [31:0] got_a [$];
    bit          rec_a = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            cnt[n] = 0; lsel[n] = 0; serr[n] = 1'b0;
        end
    endtask

    task automatic set_default_ch();
        ch[0] = 32'h0000_AAAA; ch[1] = 32'h0000_BBBB; ch[2] = 32'h0000_CCCC;
        ch[3] = 32'h0000_DDDD; ch[4] = 32'h0000_EEEE;
    endtask

    // Applies the current inputs for one cycle, compares all instances mid-cycle
    // against the model, then advances the model across the clock edge.
    task automatic drive_cycle();
        bit prdy, pvld, bad;
        int st, eff, lim;
        logic [31:0] d, mask;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            prdy = rst_n && ((cnt[n] < PD[n]) || out_ready);
            pvld = rst_n && (cnt[n] > 0) && (qp[n][0] == PD[n] - 1);
            s_rdy[n] = o_rdy[n]; s_vld[n] = o_vld[n]; s_err[n] = o_err[n];
            s_serr[n] = o_serr[n]; s_dat[n] = o_dat[n];
            p_acc[n] = in_valid && prdy;
            vectors++;
            if (o_rdy[n] !== prdy) begin
                miscompares++;
                $display("FAIL in_ready[%0d] t=%0t got %b want %b", n, $time, o_rdy[n], prdy);
            end
            vectors++;
            if (o_vld[n] !== pvld) begin
                miscompares++;
                $display("FAIL out_valid[%0d] t=%0t got %b want %b", n, $time, o_vld[n], pvld);
            end
            if (pvld) begin
                vectors++;
                if (o_dat[n] !== qd[n][0]) begin
                    miscompares++;
                    $display("FAIL out_data[%0d] t=%0t got %h want %h", n, $time, o_dat[n], qd[n][0]);
                end
                vectors++;
                if (o_err[n] !== qe[n][0]) begin
                    miscompares++;
                    $display("FAIL out_err[%0d] t=%0t got %b want %b", n, $time, o_err[n], qe[n][0]);
                end
            end
            vectors++;
            if (o_serr[n] !== serr[n]) begin
                miscompares++;
                $display("FAIL sel_err[%0d] t=%0t got %b want %b", n, $time, o_serr[n], serr[n]);
            end
            if (n == 0 && rec_a && pvld && out_ready) got_a.push_back(o_dat[0]);
            if (rst_n) begin
                st   = int'(sel_raw) & ((1 << PS[n]) - 1);
                eff  = lock_en ? lsel[n] : st;
                bad  = (eff >= PN[n]);
                mask = (PW[n] == 32) ? 32'hFFFF_FFFF : ((32'd1 << PW[n]) - 32'd1);
                if (bad) d = 32'd0;
                else     d = ch[eff] & mask;
                if (p_acc[n] && !lock_en) lsel[n] = st;
                if (p_acc[n] && bad) serr[n] = 1'b1;
                else if (err_clr)    serr[n] = 1'b0;
                if (pvld && out_ready) begin
                    for (int i = 0; i < cnt[n] - 1; i++) begin
                        qd[n][i] = qd[n][i+1]; qe[n][i] = qe[n][i+1]; qp[n][i] = qp[n][i+1];
                    end
                    cnt[n]--;
                end
                // Each beat moves one stage unless the beat ahead of it blocks.
                for (int i = 0; i < cnt[n]; i++) begin
                    lim = (i == 0) ? PD[n] - 1 : qp[n][i-1] - 1;
                    qp[n][i] = (qp[n][i] + 1 < lim) ? qp[n][i] + 1 : lim;
                end
                if (p_acc[n]) begin
                    qd[n][cnt[n]] = d; qe[n][cnt[n]] = bad; qp[n][cnt[n]] = 0;
                    cnt[n]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (o_vld[n] !== 1'b0 || o_rdy[n] !== 1'b0 || o_serr[n] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d] got vld=%b rdy=%b serr=%b want 0 0 0",
                         n, o_vld[n], o_rdy[n], o_serr[n]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (o_vld[n] !== 1'b0 || o_rdy[n] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_release[%0d] got vld=%b rdy=%b want 0 1", n, o_vld[n], o_rdy[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sels [3] = '{1, 0, 2};
        logic [31:0] exp_a [3] = '{32'h0000_BBBB, 32'h0000_AAAA, 32'h0000_CCCC};
        set_default_ch();
        out_ready = 1'b1; lock_en = 1'b0; err_clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            sel_raw  = (c < 3) ? 4'(sels[c]) : 4'd0;
            drive_cycle();
            vectors++;
            if (c >= 2 && c < 5) begin
                if (s_vld[0] !== 1'b1 || s_dat[0] !== exp_a[c-2] || s_err[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_out c=%0d got vld=%b data=%h err=%b want 1 %h 0",
                             c, s_vld[0], s_dat[0], s_err[0], exp_a[c-2]);
                end
            end else if (s_vld[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle c=%0d got vld=%b want 0", c, s_vld[0]);
            end
            if (c == 1) begin
                vectors++;
                if (s_vld[1] !== 1'b1 || s_dat[1] !== 32'h0000_00BB) begin
                    miscompares++;
                    $display("FAIL lat_depth1 got vld=%b data=%h want 1 000000bb", s_vld[1], s_dat[1]);
                end
            end
            if (c == 4) begin
                vectors++;
                if (s_vld[2] !== 1'b1 || s_dat[2] !== 32'h0000_BBBB) begin
                    miscompares++;
                    $display("FAIL lat_depth4 got vld=%b data=%h want 1 0000bbbb", s_vld[2], s_dat[2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int stall_low = 0;
        got_a.delete();
        rec_a = 1'b1;
        sel_raw = 4'd0; lock_en = 1'b0; err_clr = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid  = (sent < 8);
            for (int i = 0; i < 5; i++) ch[i] = 32'h0100 + 32'(sent);
            out_ready = !(c >= 3 && c <= 6);
            drive_cycle();
            if (p_acc[0]) sent++;
            if (c >= 3 && c <= 6 && !s_rdy[0]) stall_low++;
        end
        rec_a = 1'b0;
        vectors++;
        if (stall_low == 0) begin
            miscompares++;
            $display("FAIL bp_ready_drop got %0d low cycles want >0", stall_low);
        end
        vectors++;
        if (got_a.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count got %0d want 8", got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 8; i++) begin
            vectors++;
            if (got_a[i] !== 32'h0100 + 32'(i)) begin
                miscompares++;
                $display("FAIL bp_order[%0d] got %h want %h", i, got_a[i], 32'h0100 + 32'(i));
            end
        end
    endtask

    task automatic test_lock();
        logic [31:0] exp_a [5] = '{32'h0000_CCCC, 32'h0000_CCCC, 32'h0000_CCCC,
                                   32'h0000_CCCC, 32'h0000_BBBB};
        set_default_ch();
        out_ready = 1'b1; err_clr = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 5);
            lock_en  = (c >= 1 && c <= 3);
            sel_raw  = (c == 0) ? 4'd2 : ((c == 4) ? 4'd1 : 4'd0);
            drive_cycle();
            if (c >= 2) begin
                vectors++;
                if (s_vld[0] !== 1'b1 || s_dat[0] !== exp_a[c-2]) begin
                    miscompares++;
                    $display("FAIL lock_out c=%0d got vld=%b data=%h want 1 %h",
                             c, s_vld[0], s_dat[0], exp_a[c-2]);
                end
            end
        end
        in_valid = 1'b0; lock_en = 1'b0;
        repeat (4) drive_cycle();
    endtask

    task automatic test_sel_error();
        set_default_ch();
        out_ready = 1'b1; lock_en = 1'b0;
        in_valid = 1'b1; sel_raw = 4'd3; err_clr = 1'b0;
        drive_cycle();
        in_valid = 1'b0;
        drive_cycle();
        vectors++;
        if (s_serr[0] !== 1'b1) begin
            miscompares++; $display("FAIL err_set got %b want 1", s_serr[0]);
        end
        drive_cycle();
        vectors++;
        if (s_vld[0] !== 1'b1 || s_dat[0] !== 32'd0 || s_err[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL err_beat got vld=%b data=%h err=%b want 1 0 1", s_vld[0], s_dat[0], s_err[0]);
        end
        err_clr = 1'b1;
        drive_cycle();
        vectors++;
        if (s_serr[0] !== 1'b1) begin
            miscompares++; $display("FAIL err_sticky got %b want 1", s_serr[0]);
        end
        in_valid = 1'b1; sel_raw = 4'd3;
        drive_cycle();
        vectors++;
        if (s_serr[0] !== 1'b0) begin
            miscompares++; $display("FAIL err_clear got %b want 0", s_serr[0]);
        end
        in_valid = 1'b0; err_clr = 1'b0;
        drive_cycle();
        vectors++;
        if (s_serr[0] !== 1'b1) begin
            miscompares++; $display("FAIL err_set_wins got %b want 1", s_serr[0]);
        end
        drive_cycle();
        vectors++;
        if (s_vld[0] !== 1'b1 || s_err[0] !== 1'b1) begin
            miscompares++; $display("FAIL err_beat2 got vld=%b err=%b want 1 1", s_vld[0], s_err[0]);
        end
        in_valid = 1'b1; sel_raw = 4'd6; err_clr = 1'b1;
        drive_cycle();
        in_valid = 1'b0; err_clr = 1'b0;
        drive_cycle();
        vectors++;
        if (s_serr[0] !== 1'b0 || s_serr[1] !== 1'b0 || s_serr[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL err_per_cfg got %b%b%b want 001", s_serr[0], s_serr[1], s_serr[2]);
        end
        repeat (5) drive_cycle();
        err_clr = 1'b1;
        drive_cycle();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        int first = -1;
        logic [31:0] fd = 32'd0;
        set_default_ch();
        out_ready = 1'b1; lock_en = 1'b0; err_clr = 1'b0;
        in_valid = 1'b1; sel_raw = 4'd1;
        drive_cycle();
        drive_cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (o_vld[n] !== 1'b0 || o_rdy[n] !== 1'b0) begin
                miscompares++;
                $display("FAIL flight_reset[%0d] got vld=%b rdy=%b want 0 0", n, o_vld[n], o_rdy[n]);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ch[0] = 32'h0000_5A5A;
        sel_raw = 4'd0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            drive_cycle();
            if (first < 0 && s_vld[0]) begin
                first = c; fd = s_dat[0];
            end
        end
        vectors++;
        if (first != 2 || fd !== 32'h0000_5A5A) begin
            miscompares++;
            $display("FAIL flight_first got cycle=%0d data=%h want 2 00005a5a", first, fd);
        end
    endtask

    task automatic test_random();
        lock_en = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            sel_raw   = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) lock_en = ~lock_en;
            err_clr   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 5; i++) ch[i] = $urandom;
            drive_cycle();
        end
        in_valid = 1'b0; lock_en = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        repeat (6) drive_cycle();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; lock_en = 1'b0; err_clr = 1'b0;
        out_ready = 1'b0; sel_raw = 4'd0;
        set_default_ch();
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_lock();
        test_sel_error();
        test_reset_in_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
